// File: rtl/lane_byte_packer.sv
// rtl/lane_byte_packer.sv - four-lane byte deskew FIFOs packed into a 32-bit valid/ready word
// Optional LANE_PACKER_STATS_EN adds word_count and drop_count outputs.
module lane_byte_packer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in0,
    input  logic [7:0]  in1,
    input  logic [7:0]  in2,
    input  logic [7:0]  in3,
    input  logic        valid0,
    input  logic        valid1,
    input  logic        valid2,
    input  logic        valid3,
    input  logic        out_ready,
    output logic [31:0] data_out,
    output logic        valid_out,
`ifdef LANE_PACKER_STATS_EN
    output logic [15:0] word_count,
    output logic [7:0]  drop_count,
`endif
    output logic        overflow
);

    localparam int LANES = 4;

    logic [7:0]      lane_in    [LANES];
    logic [LANES-1:0] lane_valid;
    logic [7:0]      mem        [LANES][DEPTH];
    logic [ADDR_W:0] wr_ptr     [LANES];
    logic [ADDR_W:0] rd_ptr     [LANES];
    logic [7:0]      head       [LANES];
    logic [LANES-1:0] empty;
    logic [LANES-1:0] full;
    logic [LANES-1:0] push;
    logic [LANES-1:0] drop;
    logic            pop;

    assign lane_in[0] = in0;
    assign lane_in[1] = in1;
    assign lane_in[2] = in2;
    assign lane_in[3] = in3;
    assign lane_valid = {valid3, valid2, valid1, valid0};

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][ADDR_W] != rd_ptr[i][ADDR_W]) &&
                       (wr_ptr[i][ADDR_W-1:0] == rd_ptr[i][ADDR_W-1:0]);
            head[i]  = mem[i][rd_ptr[i][ADDR_W-1:0]];
        end
    end

    assign pop = (empty == '0) && (!valid_out || out_ready);

    // A full lane that pops this cycle frees the slot the push lands in.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            push[i] = lane_valid[i] && (!full[i] || pop);
            drop[i] = lane_valid[i] && full[i] && !pop;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (!reset && push[i]) begin
                mem[i][wr_ptr[i][ADDR_W-1:0]] <= lane_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            data_out  <= 32'h0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + (ADDR_W+1)'(1);
                end
                if (pop) begin
                    rd_ptr[i] <= rd_ptr[i] + (ADDR_W+1)'(1);
                end
            end
            if (pop) begin
                data_out  <= {head[3], head[2], head[1], head[0]};
                valid_out <= 1'b1;
            end else if (valid_out && out_ready) begin
                valid_out <= 1'b0;
            end
            if (drop != '0) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef LANE_PACKER_STATS_EN
    logic [2:0] drop_sum;
    logic [8:0] drop_total;

    always_comb begin
        drop_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            drop_sum = drop_sum + {2'b00, drop[i]};
        end
        drop_total = {1'b0, drop_count} + {6'b0, drop_sum};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_count <= 16'h0;
            drop_count <= 8'h0;
        end else begin
            if (pop) begin
                word_count <= word_count + 16'h1;
            end
            drop_count <= drop_total[8] ? 8'hFF : drop_total[7:0];
        end
    end
`endif

endmodule
